// File: rtl/bus_unpermute_if.sv
// Stream bundle for the permuted-bus decoder: scrambled input beats in,
// restored output beats out, each with its own valid/ready pair.
interface bus_unpermute_if #(
    parameter int WIDTH = 3
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/bus_unpermute.sv
// Receive-side bit-order decoder: d[p[k]] = s[k] ^ pol[k] with a programmable
// map, a 1-deep registered valid/ready output stage and an accepted-beat counter.
module bus_unpermute #(
    parameter int WIDTH = 3,
    parameter int IDXW  = 2,
    parameter int CNTW  = 16
) (
    input  logic            clk,
    input  logic            rst,
    bus_unpermute_if.slave  bus,
    input  logic            cfg_we,
    input  logic [IDXW-1:0] cfg_idx,
    input  logic [IDXW-1:0] cfg_src,
    input  logic            cfg_pol,
    output logic            map_err,
    output logic [CNTW-1:0] beat_cnt
);

    logic [IDXW-1:0]  p_reg [WIDTH];
    logic [WIDTH-1:0] pol_reg;
    logic [WIDTH-1:0] dec;
    logic [WIDTH-1:0] out_data_reg;
    logic             out_valid_reg;
    logic             map_err_reg;
    logic             err_next;
    logic [CNTW-1:0]  cnt_reg;
    logic             ready;
    logic             accept;

    // Map storage; an index outside the bus simply matches no entry.
    always_ff @(posedge clk) begin
        for (int k = 0; k < WIDTH; k++) begin
            if (rst) begin
                p_reg[k]   <= IDXW'(k);
                pol_reg[k] <= 1'b0;
            end else if (cfg_we && (cfg_idx == IDXW'(k))) begin
                p_reg[k]   <= cfg_src;
                pol_reg[k] <= cfg_pol;
            end
        end
    end

    // Each restored bit gathers the scrambled bits whose map entry points at it.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : gen_dec
            logic [WIDTH-1:0] hit;
            for (genvar gk = 0; gk < WIDTH; gk++) begin : gen_hit
                assign hit[gk] = (p_reg[gk] == IDXW'(gi));
            end
            assign dec[gi] = |(hit & (bus.in_data ^ pol_reg));
        end
    endgenerate

    // Extra top bit keeps the range check correct when WIDTH == 2**IDXW.
    always_comb begin
        err_next = 1'b0;
        for (int k = 0; k < WIDTH; k++) begin
            if ({1'b0, p_reg[k]} >= (IDXW+1)'(WIDTH)) begin
                err_next = 1'b1;
            end
            for (int j = k + 1; j < WIDTH; j++) begin
                if (p_reg[k] == p_reg[j]) begin
                    err_next = 1'b1;
                end
            end
        end
    end

    assign ready  = !map_err_reg && (!out_valid_reg || bus.out_ready);
    assign accept = bus.in_valid && ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            map_err_reg   <= 1'b0;
            cnt_reg       <= '0;
        end else begin
            map_err_reg <= err_next;
            if (accept) begin
                out_valid_reg <= 1'b1;
                out_data_reg  <= dec;
                cnt_reg       <= cnt_reg + 1'b1;
            end else if (bus.out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_data  = out_data_reg;
    assign map_err       = map_err_reg;
    assign beat_cnt      = cnt_reg;

endmodule

// File: doc/bus_unpermute.md
Name: bus_unpermute

Overview:
- Receive-side bus bit-order decoder. Takes a word whose bits were reordered, and optionally inverted, by a hierarchical bus connect. Restores the original bit order and polarity.
- Sits at the consumer end of a permuted bus.
- The permutation map and polarity mask are run-time programmable through a config port.
- The data path is a 1-deep registered valid/ready stage with a beat counter.

Parameters:
- WIDTH, 3, bus width in bits (2..16).
- IDXW, 2, width of a bit index; must satisfy 2^IDXW >= WIDTH.
- CNTW, 16, width of the accepted-beat counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  WIDTH  scrambled word s.
- in_valid  in  1  s is valid.
- in_ready  out  1  block accepts s this cycle.
- out_data  out  WIDTH  restored word d.
- out_valid  out  1  d is valid.
- out_ready  in  1  consumer accepts d.
- cfg_we  in  1  write one map entry.
- cfg_idx  in  IDXW  scrambled-bit position k being written.
- cfg_src  in  IDXW  original-bit position p[k] for that k.
- cfg_pol  in  1  inversion flag for position k.
- map_err  out  1  stored map is not a valid permutation.
- beat_cnt  out  CNTW  count of accepted input beats.

Behaviour:
- Decode rule: d[p[k]] = s[k] XOR pol[k], for every k in 0..WIDTH-1. This is the inverse of the forward connect s[k] = d[p[k]] XOR pol[k].
- Reset values:
  - p[k] = k (identity map); pol = 0.
  - out_valid = 0; out_data = 0.
  - map_err = 0; beat_cnt = 0.
  - in_ready = 1 in the cycle after rst deasserts.
- Reset mid-operation: any held output beat is dropped and the map returns to identity. rst overrides cfg_we and in_valid in the same cycle.
- Handshake:
  - in_ready = !map_err && (!out_valid || out_ready).
  - Accept occurs when in_valid && in_ready; the decoded word is registered into out_data and out_valid = 1 on the next edge.
  - Latency is 1 cycle. Throughput is 1 beat/cycle when out_ready stays high.
  - A held beat leaves when out_valid && out_ready. If there is no accept in the same cycle, out_valid drops to 0.
  - While out_valid && !out_ready, out_data is stable and in_ready = 0.
- Config:
  - cfg_we with cfg_idx < WIDTH writes p[cfg_idx] = cfg_src and pol[cfg_idx] = cfg_pol at the edge.
  - A beat accepted in the same cycle as cfg_we decodes with the pre-write map.
  - The new map applies to beats accepted from the next cycle on.
  - cfg_we with cfg_idx >= WIDTH is ignored.
- Map check:
  - map_err is registered and recomputed every cycle from the stored map.
  - map_err = 1 if any p[k] >= WIDTH, or if any two entries are equal.
  - map_err is visible one cycle after the offending write.
  - It clears one cycle after a write restores a valid permutation.
  - A beat already held in the output stage still drains normally while map_err = 1.
- Beat counter: beat_cnt increments by 1 per accepted beat and wraps from 2^CNTW-1 to 0. It is unaffected by config writes.

Test Plan:
- Identity map after reset; stream s = 101, 010 with out_ready = 1 -> out_data = 101, 010 on consecutive cycles, each 1 cycle after accept; beat_cnt = 2.
- WIDTH=3; write p[2]=0, p[1]=2, p[0]=1, pol=0; send s = 100 -> out_data = 001; then send s = 011 -> out_data = 110.
- Identity map with pol[0]=1; send s = 000 -> out_data = 001. Same beat sent together with a cfg_we changing pol[0] back to 0 -> out_data = 001 (old map applies); next beat s = 000 -> out_data = 000.
- Hold out_ready = 0 for 3 cycles with a beat held -> out_valid = 1, out_data stable, in_ready = 0, beat_cnt unchanged; on release the next beat is accepted the same cycle.
- Write p[0]=1 so the map is {1,1,2} -> map_err = 1 next cycle and in_ready = 0; write p[1]=0 -> map_err = 0 and in_ready = 1 one cycle later. Write p[2]=3 -> map_err = 1.
- CNTW=4: accept 17 beats -> beat_cnt = 1. Assert rst while a beat is held -> out_valid = 0, map is identity, beat_cnt = 0 next cycle.
